// File: rtl/fanout_token_sched.sv
// One-to-many token fanout: holds one source token until every active destination has taken it.
// Destinations are tracked with a served mask, so each one may accept in a different cycle.
module fanout_token_sched #(
    parameter int NUM_DST    = 20,
    parameter int DATA_WIDTH = 17,
    parameter int SEL_WIDTH  = 8,
    parameter int SEL_BIT    = 5,
    parameter int STALL_W    = 16
) (
    input  logic                           CLK,
    input  logic                           ASYNCRESET,
    input  logic                           flush,
    input  logic [NUM_DST-1:0]             dst_en,
    input  logic [NUM_DST*SEL_WIDTH-1:0]   dst_sel,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [NUM_DST-1:0]             out_valid,
    input  logic [NUM_DST-1:0]             dst_ready,
    output logic                           busy,
    output logic [STALL_W-1:0]             stall_cycles
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [NUM_DST-1:0]      served_q, served_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [STALL_W-1:0]      stall_q;

    logic [NUM_DST-1:0]      active;
    logic [NUM_DST-1:0]      fire;
    logic                    full;
    logic                    done;
    logic                    accept;
    logic                    load;
    logic                    stall_inc;

    // Activity is re-evaluated every cycle so configuration changes apply mid-token.
    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_DST; i++) begin
            active[i] = dst_en[i] & dst_sel[i*SEL_WIDTH + SEL_BIT];
        end
    end

    assign full      = (state_q == S_FULL);
    assign out_valid = {NUM_DST{full}} & active & ~served_q;
    assign fire      = out_valid & dst_ready;
    assign done      = full & ~|(active & ~served_q & ~fire);
    assign in_ready  = ~flush & (~full | done);
    assign accept    = in_valid & in_ready;
    assign stall_inc = full & ~done & ~flush;

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        load     = 1'b0;
        if (flush) begin
            state_d  = S_EMPTY;
            served_d = '0;
        end else if (accept) begin
            load     = 1'b1;
            state_d  = S_FULL;
            served_d = '0;
        end else if (state_q == S_FULL) begin
            if (done) begin
                state_d  = S_EMPTY;
                served_d = '0;
            end else begin
                served_d = served_q | fire;
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q  <= S_EMPTY;
            served_q <= '0;
            data_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            if (load) begin
                data_q <= in_data;
            end
            // Saturates so a long-blocked consumer cannot wrap the count back to small values.
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

    assign out_data     = data_q;
    assign busy         = full;
    assign stall_cycles = stall_q;

endmodule

// File: doc/fanout_token_sched.md
# fanout_token_sched

Sequencing controller for a one-to-many interconnect fanout. It latches one token from a single source and delivers it to every active destination track; each destination may accept in a different cycle. Upstream ready is released only once all active destinations have taken the token. This replaces the all-destinations-ready-in-the-same-cycle AND-reduction with per-destination served tracking, so one slow consumer no longer forces the rest to wait for simultaneous readiness.

## Interface
Parameters:
- NUM_DST, 20, number of fanout destinations
- DATA_WIDTH, 17, token width
- SEL_WIDTH, 8, width of each destination's mux-select field
- SEL_BIT, 5, select bit marking this source as the destination's driver
- STALL_W, 16, stall counter width

Ports:
- CLK  in  1  clock, rising edge
- ASYNCRESET  in  1  asynchronous reset, active-high
- flush  in  1  synchronous clear of the held token
- dst_en  in  NUM_DST  per-destination enable
- dst_sel  in  NUM_DST*SEL_WIDTH  packed selects; destination i uses bits [i*SEL_WIDTH +: SEL_WIDTH]
- in_data  in  DATA_WIDTH  source token
- in_valid  in  1  source valid
- in_ready  out  1  source ready
- out_data  out  DATA_WIDTH  held token, broadcast to all destinations
- out_valid  out  NUM_DST  per-destination valid
- dst_ready  in  NUM_DST  per-destination ready
- busy  out  1  token held
- stall_cycles  out  STALL_W  saturating count of blocked cycles

## Operation
- active[i] = dst_en[i] & dst_sel[i*SEL_WIDTH+SEL_BIT]. It is evaluated combinationally every cycle, so config changes take effect immediately.
- State: EMPTY or FULL (1 bit `full`), plus a data register and a served mask `served[NUM_DST]`.
- out_valid[i] = full & active[i] & ~served[i].
- fire[i] = out_valid[i] & dst_ready[i].
- done = full & ((active & ~served & ~fire) == 0). All remaining active destinations are served this cycle, or none remain.
- in_ready = ~full | done. Combinational path from dst_ready to in_ready is intended.
- accept = in_valid & in_ready.
- EMPTY:
  - on accept: data <= in_data, served <= 0, go to FULL.
- FULL:
  - if accept: data <= in_data, served <= 0, stay FULL (back-to-back).
  - else if done: go to EMPTY, served <= 0.
  - else: served <= served | fire.
- Destination deactivated mid-token: it is dropped from the requirement, and its served bit is don't-care.
- Destination activated mid-token: it must also receive the current token before done.
- Zero active destinations while FULL: done in that cycle and the token is discarded.
- flush has priority over all else: full <= 0, served <= 0; in_ready is forced 0 that cycle; the data register is unchanged.
- busy = full.
- stall_cycles: increments when full & ~done & ~flush, saturates at all-ones, and clears only on reset.

## Timing
- Reset values:
  - full=0, served=0, data=0, stall_cycles=0.
  - Hence out_valid=0, out_data=0, busy=0, in_ready=1.
- Latency: a token accepted at edge N is presented on out_data/out_valid in cycle N+1.
- Throughput: one token per cycle when every active destination is ready the cycle after acceptance.
- Handshakes:
  - Each destination transfer occurs when out_valid[i] & dst_ready[i] at the rising edge.
  - out_valid[i] never re-asserts for the same token after its transfer.
  - out_data is stable while full.
- Reset asserted mid-token: state clears immediately (asynchronously) and the token is lost.

## Test plan
- Reset, then all 20 destinations enabled with SEL bit 5 set, dst_ready all 1, stream tokens 0x00001..0x00008 -> in_ready stays 1, each destination sees each token exactly once, one per cycle; stall_cycles=0.
- Active destinations {0,3,19}, in_data=0x1ABCD; ready dst0 cycle 1, dst3 cycle 3, dst19 cycle 5 -> out_valid[0] drops after cycle 1, out_valid[3] after cycle 3; in_ready=1 only in cycle 5; stall_cycles=4.
- While FULL and waiting on dst7, clear dst_en[7] -> done the same cycle, in_ready=1, next token accepted.
- dst_en all 1 but every SEL bit 5 clear, in_valid=1 with token 0x00055 -> token is accepted, FULL for one cycle, then dropped with no out_valid.
- FULL with dst2 pending, assert flush -> the next cycle has busy=0 and out_valid=0; in_ready=0 during the flush cycle.
- Hold dst5 never ready for 70000 cycles -> stall_cycles saturates at 0xFFFF; assert ASYNCRESET mid-cycle -> all outputs return to their reset values without waiting for a clock edge.
